ysyx_24100005_ifu: RTL
======================

# ysyx_24100005_ifu

Instruction-fetch controller for the NPC core. It owns the architectural PC and sequences fetches: one read request per instruction to instruction memory over a valid/ready channel. The fetched word goes to decode over a valid/ready channel, and the PC advances by 4 or takes a redirect. It replaces the free-running PC+4 register so that fetch can stall, wait on memory latency, flush on jumps/branches and halt.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, always word-aligned
- imem_rsp_valid  in  1  response valid; arrives no earlier than the cycle after acceptance
- imem_rsp_data  in  32  fetched instruction word
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word (registered)
- inst_pc  out  32  PC of inst
- redirect_valid  in  1  control-flow redirect (jump/branch/trap)
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- halt  in  1  level; stop issuing new fetches (ebreak)
- fetch_fault  out  1  sticky access fault, cleared by redirect

## Operation
- States:
  - REQ: imem_req_valid=1, imem_req_addr=pc.
  - WAIT: one request is outstanding.
  - HOLD: inst_valid=1.
  - IDLE: halted.
- At most one outstanding request.
- REQ -> WAIT on imem_req_valid & imem_req_ready.
- WAIT -> HOLD on imem_rsp_valid with drop=0. Capture inst=imem_rsp_data and inst_pc=pc.
- HOLD -> REQ (or IDLE if halt) on inst_valid & inst_ready; pc <= pc + 4.
- REQ -> IDLE when halt=1 and no acceptance in that cycle. IDLE -> REQ when halt=0.
- Redirect, by state:
  - REQ, not accepted: pc <= redirect_pc; stay in REQ.
  - REQ, accepted in the same cycle: pc <= redirect_pc; go to WAIT with drop=1.
  - WAIT: pc <= redirect_pc; drop <= 1. A response with drop=1 is discarded; clear drop and go to REQ.
  - HOLD: the held instruction is discarded; pc <= redirect_pc; go to REQ. If inst_ready is also high that cycle, the handshake counts as fired, but pc still takes redirect_pc (not pc+4).
  - IDLE: pc <= redirect_pc.
  - Any state: clears fetch_fault.
- imem_rsp_err with drop=0: set fetch_fault and go to IDLE; inst_valid is not raised. Only a redirect leaves the fault state.
- Arithmetic: pc + 4 is 32-bit with wrap; 32'hFFFF_FFFC + 4 = 0.
- Responses in REQ/HOLD/IDLE are protocol errors. Ignore them; the bench asserts they never occur.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, drop=0, fetch_fault=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_req_valid=1 in the first cycle after reset release.
- All outputs are registered or decoded from state. There are no combinational paths from in to out, apart from imem_req_addr=pc.
- Minimum throughput is one instruction per 3 cycles: accept at N, response at N+1, inst_valid at N+2, next request at N+3.
- imem_req_valid, once high, stays high with a stable address until accepted, unless a redirect changes the address.
- inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
- Reset mid-operation aborts any outstanding request. After reset, memory must not deliver a stale response.

## Structure
- Package ysyx_24100005_pkg holds:
  - ifu_state_e enum (IDLE, REQ, WAIT, HOLD)
  - RESET_PC_DEFAULT constant
  - INST_NOP = 32'h0000_0013
- One sub-module, ysyx_24100005_pc_gen: combinational next-PC select (redirect_pc & ~3, pc + 4, or hold), instantiated inside the IFU.
- PC, inst, inst_pc, drop and fault are local registers in the IFU.

## Test plan
- Reset release, memory always ready with 1-cycle response -> addresses 8000_0000, 8000_0004, 8000_0008; inst_valid every 3rd cycle with matching inst_pc.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable; no new imem_req_valid; pc advances only after ready.
- Redirect to 8000_0103 during WAIT -> the in-flight response is dropped (no inst_valid); next request is 8000_0100.
- Response with imem_rsp_err=1 -> fetch_fault=1, state IDLE, no requests. Redirect to 8000_0200 -> fault clears and a fetch to 8000_0200 is issued.
- halt=1 during WAIT -> current instruction delivered, then no request until halt=0. Redirect and halt in the same cycle -> pc updated and no fetch.
- rst pulled low during WAIT -> outputs at reset values asynchronously. After release, the first request goes to RESET_PC.

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
// Shared types and constants for the ysyx_24100005 instruction-fetch unit.
//   ifu_state_e      : fetch sequencer states
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden by the IFU parameter
//   INST_NOP         : canonical no-op encoding (addi x0, x0, 0)
package ysyx_24100005_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24100005_pc_gen.sv
// Next-PC select for the fetch unit (purely combinational).
//   pc             : current architectural PC
//   redirect_valid : take redirect_pc (highest priority)
//   redirect_pc    : redirect target; low two bits are forced to zero
//   advance        : decode consumed the held instruction, step to pc + 4
//   pc_next        : selected next PC (hold when neither condition applies)
module ysyx_24100005_pc_gen
  import ysyx_24100005_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (advance) begin
      // 32-bit add wraps naturally: FFFF_FFFC + 4 = 0
      pc_next = pc + 32'd4;
    end
  end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction-fetch controller: owns the PC, issues one memory read per
// instruction, holds the fetched word for decode, and follows redirects.
//   clk, rst                        : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       : fetch request channel (addr = pc)
//   imem_rsp_valid/data/err         : fetch response, one per accepted request
//   inst_valid/ready, inst, inst_pc : instruction channel to decode
//   redirect_valid/pc               : control-flow redirect, any state
//   halt                            : level, stop issuing new fetches
//   fetch_fault                     : sticky access fault, cleared by redirect
//   dbg_state                       : current sequencer state (ifu_state_e)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; valid never depends combinationally on
// ready and, once high, holds its payload until the transfer (a redirect may
// change the request address, and a redirect withdraws a held instruction).
module ysyx_24100005_ifu
  import ysyx_24100005_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        drop_q, drop_d;
  logic        fault_q, fault_d;
  logic        req_fire;
  logic        inst_fire;
  logic        rsp_stale;

  assign req_fire  = (state_q == REQ) & imem_req_ready;
  assign inst_fire = (state_q == HOLD) & inst_ready;
  // A redirect arriving together with the response makes that response stale
  // just like an earlier one would.
  assign rsp_stale = drop_q | redirect_valid;

  ysyx_24100005_pc_gen u_pc_gen (
    .pc             (pc_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (inst_fire),
    .pc_next        (pc_d)
  );

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = redirect_valid ? 1'b0 : fault_q;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end else if (halt) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (rsp_stale) begin
            state_d = halt ? IDLE : REQ;
          end else if (imem_rsp_err) begin
            state_d = IDLE;
            fault_d = 1'b1;
          end else begin
            state_d   = HOLD;
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        // A redirect discards the held word whether or not decode took it.
        if (redirect_valid || inst_ready) begin
          state_d = halt ? IDLE : REQ;
        end
      end
      IDLE: begin
        // A pending fault pins the unit here until a redirect arrives.
        if (!halt && (redirect_valid || !fault_q)) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
      drop_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      drop_q    <= drop_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = fault_q;
  assign dbg_state      = state_q;

endmodule
